uart_rx_fifo: RTL
=================

Name: uart_rx_fifo

Overview:
Receive buffer sitting directly downstream of the UART receiver. It captures each received character, tagged with its parity and framing error status, into a first-word-fall-through FIFO. It exposes a pop interface to the register/bus block and provides level, threshold, overrun and optional idle-timeout status for interrupt generation.

Parameters:
DEPTH, 16, number of entries; power of two, minimum 2.
AW, $clog2(DEPTH), pointer width; derived, do not override.

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
clear  input  1  synchronous flush of contents, pending error tags, overrun and timeout
rx_data  input  8  character from receiver, valid with rx_valid
rx_valid  input  1  one-cycle pulse, character complete
rx_parity_err  input  1  one-cycle pulse, parity mismatch on current character
rx_frame_err  input  1  one-cycle pulse, stop bit sampled low
rd_en  input  1  pop request
rd_data  output  8  head entry data, valid while empty=0
rd_perr  output  1  head entry parity error tag
rd_ferr  output  1  head entry framing error tag
empty  output  1  no entries
full  output  1  DEPTH entries
level  output  AW+1  current entry count
thresh  input  AW+1  threshold for thresh_hit
thresh_hit  output  1  level >= thresh, with thresh != 0
overrun  output  1  sticky, a character was dropped
overrun_clr  input  1  clears overrun
osr_tick  input  1  oversample tick, same as the receiver's; used only by the timeout
to_ticks  input  16  idle timeout in osr ticks; 0 disables
timeout  output  1  sticky idle timeout

Behaviour:
- Reset: pointers 0, level 0, empty=1, full=0, overrun=0, timeout=0, pending tags 0, thresh_hit=0. rd_data, rd_perr and rd_ferr read 0 while empty.
- Error tagging: rx_parity_err and rx_frame_err pulses arrive on earlier cycles than rx_valid, or on the same cycle (in 2-stop mode a framing pulse may precede rx_valid).
  - Each pulse sets a pending bit (perr_p, ferr_p).
  - On rx_valid, the written tag = pending bit OR same-cycle pulse. Both pending bits then clear.
  - If the write is dropped, the pending bits still clear.
- Write: rx_valid and (!full or rd_en) → entry {perr, ferr, data} stored at wr_ptr, wr_ptr+1 (wraps mod DEPTH).
- Write while full without rd_en → character dropped, overrun set. Contents unchanged.
- Read: FWFT. rd_data, rd_perr and rd_ferr are combinational from the head entry. rd_en with !empty → rd_ptr+1, wraps mod DEPTH. rd_en while empty is ignored, with no underflow.
- Simultaneous push and pop:
  - Level unchanged.
  - When empty, the pop is ignored and the push is accepted; level becomes 1 and the head is visible the next cycle.
  - When full, both are accepted.
- Latency: write on cycle N, head visible and empty=0 on cycle N+1.
- level, empty and full are registered and consistent with the pointers every cycle.
- Overrun: set has priority over overrun_clr in the same cycle. clear also resets overrun.
- clear: pointers, level, pending bits and timeout go to 0 next cycle. Any rx_valid in the same cycle is discarded and does not set overrun.
- thresh_hit is combinational from registered level; it is 0 when thresh=0.

Optional Feature:
- Macro: UART_RX_FIFO_TIMEOUT_EN.
- Enabled:
  - A 16-bit idle counter resets to 0 on any accepted push, any accepted pop, clear, or empty=1.
  - Otherwise it increments on osr_tick, saturating.
  - When the counter reaches to_ticks (to_ticks != 0), timeout sets and stays set until an accepted push, accepted pop, or clear.
- Disabled: timeout is tied 0; osr_tick and to_ticks are ignored; no counter is instantiated.

Decomposition:
- Package uart_pkg:
  - rx_fifo_entry_t, a packed struct {perr, ferr, data[7:0]}.
  - Constant UART_RX_TO_W = 16.
- Sub-module uart_sync_fifo: generic FWFT storage with pointers, level and flags, parameterised by DEPTH and entry width.
- uart_rx_fifo holds the tagging, overrun, threshold and timeout logic.

Test Plan:
- Push 0x41, 0x42, 0x43 with no errors → rd_data shows 0x41 one cycle after the first push; pops return 0x41, 0x42, 0x43; level 3→0; empty=1.
- rx_parity_err pulse 10 cycles before rx_valid (0x55), then rx_frame_err coincident with rx_valid (0xAA) → entry 0x55 has perr=1, ferr=0; entry 0xAA has perr=0, ferr=1.
- Fill to 16, push 0x99 without rd_en → dropped, overrun=1, level 16. Push with rd_en on the same cycle → accepted, level 16. overrun_clr → overrun=0.
- thresh=4: 3 pushes → thresh_hit=0; 4th push → 1; one pop → 0. With thresh=0, thresh_hit stays 0 at any level.
- Pop while empty, then simultaneous push (0x12) and pop while empty → level 1, rd_data=0x12. clear with 5 entries plus a same-cycle rx_valid → level 0, no overrun.
- Timeout build (UART_RX_FIFO_TIMEOUT_EN), to_ticks=8, one entry, osr_tick every cycle → timeout=1 after the 8th tick. A pop clears it. Set again, then assert rst_n low mid-count → all outputs return to reset values.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types for the UART receive path: the tagged receive-FIFO entry and
// the idle-timeout counter width.
package uart_pkg;

   typedef struct packed {
      logic       perr;
      logic       ferr;
      logic [7:0] data;
   } rx_fifo_entry_t;

   localparam int UART_RX_TO_W = 16;
   localparam int RX_ENTRY_W   = $bits(rx_fifo_entry_t);

endpackage

// File: rtl/uart_sync_fifo.sv
// Generic first-word-fall-through synchronous FIFO with registered level and
// flags. Head data reads as zero while empty.
module uart_sync_fifo #(
   parameter  int DEPTH = 16,
   parameter  int W     = 8,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clear,
   input  logic          wr_en,
   input  logic [W-1:0]  wr_data,
   input  logic          rd_en,
   output logic [W-1:0]  rd_data,
   output logic          empty,
   output logic          full,
   output logic [AW:0]   level,
   output logic          push_ok,
   output logic          pop_ok
);

   localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   level_nxt;

   // A pop frees the slot the push needs, so push is allowed when full if
   // a pop is requested in the same cycle.
   assign pop_ok  = rd_en & ~empty & ~clear;
   assign push_ok = wr_en & (~full | rd_en) & ~clear;

   always_comb begin
      level_nxt = level;
      if (clear) begin
         level_nxt = '0;
      end else begin
         case ({push_ok, pop_ok})
            2'b10:   level_nxt = level + (AW+1)'(1);
            2'b01:   level_nxt = level - (AW+1)'(1);
            default: level_nxt = level;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
         empty  <= 1'b1;
         full   <= 1'b0;
      end else begin
         if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
         end
         level <= level_nxt;
         empty <= (level_nxt == '0);
         full  <= (level_nxt == LVL_FULL);
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= wr_data;
   end

   assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: tags characters with parity/framing status, tracks
// overrun and threshold, and optionally flags idle timeout (UART_RX_FIFO_TIMEOUT_EN).
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter  int DEPTH = 16,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    clear,
   input  logic [7:0]              rx_data,
   input  logic                    rx_valid,
   input  logic                    rx_parity_err,
   input  logic                    rx_frame_err,
   input  logic                    rd_en,
   output logic [7:0]              rd_data,
   output logic                    rd_perr,
   output logic                    rd_ferr,
   output logic                    empty,
   output logic                    full,
   output logic [AW:0]             level,
   input  logic [AW:0]             thresh,
   output logic                    thresh_hit,
   output logic                    overrun,
   input  logic                    overrun_clr,
   input  logic                    osr_tick,
   input  logic [UART_RX_TO_W-1:0] to_ticks,
   output logic                    timeout
);

   rx_fifo_entry_t wr_entry;
   rx_fifo_entry_t rd_entry;
   logic           perr_p;
   logic           ferr_p;
   logic           push_ok;
   logic           pop_ok;
   logic           drop;

   assign wr_entry = '{perr: perr_p | rx_parity_err,
                       ferr: ferr_p | rx_frame_err,
                       data: rx_data};

   uart_sync_fifo #(.DEPTH(DEPTH), .W(RX_ENTRY_W)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (clear),
      .wr_en   (rx_valid),
      .wr_data (wr_entry),
      .rd_en   (rd_en),
      .rd_data (rd_entry),
      .empty   (empty),
      .full    (full),
      .level   (level),
      .push_ok (push_ok),
      .pop_ok  (pop_ok)
   );

   assign rd_data    = rd_entry.data;
   assign rd_perr    = rd_entry.perr;
   assign rd_ferr    = rd_entry.ferr;
   assign thresh_hit = (thresh != '0) && (level >= thresh);
   assign drop       = rx_valid & full & ~rd_en & ~clear;

   // Error pulses may lead the character; they are held until the next
   // rx_valid consumes them, whether or not that character is stored.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perr_p <= 1'b0;
         ferr_p <= 1'b0;
      end else if (clear || rx_valid) begin
         perr_p <= 1'b0;
         ferr_p <= 1'b0;
      end else begin
         if (rx_parity_err) perr_p <= 1'b1;
         if (rx_frame_err)  ferr_p <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)           overrun <= 1'b0;
      else if (clear)       overrun <= 1'b0;
      else if (drop)        overrun <= 1'b1;
      else if (overrun_clr) overrun <= 1'b0;
   end

`ifdef UART_RX_FIFO_TIMEOUT_EN
   logic [UART_RX_TO_W-1:0] idle_cnt;
   logic [UART_RX_TO_W-1:0] idle_nxt;
   logic                    activity;

   assign activity = clear | push_ok | pop_ok;

   always_comb begin
      idle_nxt = idle_cnt;
      if (activity || empty)
         idle_nxt = '0;
      else if (osr_tick && (idle_cnt != '1))
         idle_nxt = idle_cnt + UART_RX_TO_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idle_cnt <= '0;
         timeout  <= 1'b0;
      end else begin
         idle_cnt <= idle_nxt;
         if (activity)
            timeout <= 1'b0;
         else if ((to_ticks != '0) && (idle_nxt == to_ticks))
            timeout <= 1'b1;
      end
   end
`else
   logic unused_to;

   assign unused_to = ^{osr_tick, to_ticks, push_ok, pop_ok};
   assign timeout   = 1'b0;
`endif

endmodule
